// File: rtl/switch_input.sv
// ---------------------------------------------------------------------------
// switch_input
//
// Services a processor IN instruction from the board switches. While the
// processor holds input_flag, the pipeline is stalled and a prompt LED
// (waiting) is lit. The switch value is captured when the operator presses
// the push button. The button is synchronized and debounced, and only a
// fresh press made during the wait is accepted.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   reset       synchronous, active-high reset
//   halt        processor halted; aborts a pending request
//   input_flag  processor is executing an IN instruction
//   SW[17:0]    board switches, the value to be read
//   KEY         push button, active-low, asynchronous to clk
//   data_out    last captured switch value, zero-extended to 32 bits
//   stall       freezes the processor PC/pipeline while high
//   input_done  one-cycle pulse in the cycle data_out was updated
//   waiting     high while a key press is awaited
// ---------------------------------------------------------------------------
module switch_input #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic        input_flag,
  input  logic [17:0] SW,
  input  logic        KEY,
  output logic [31:0] data_out,
  output logic        stall,
  output logic        input_done,
  output logic        waiting
);

  // The counter also has to hold DEBOUNCE_CYCLES-1 when the parameter is 1.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_PRESS = 2'd1;
  localparam logic [1:0] DONE       = 2'd2;

  logic             key_sync1;
  logic             key_sync2;
  logic             key_level;
  logic [CNT_W-1:0] stable_cnt;
  logic             press_evt;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             capture;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer. Reset leaves it at the released level (1) so
  // that leaving reset cannot look like a press.
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, which makes the synchronizer chain shift
  // by one stage per clock instead of collapsing into a single flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_sync1 <= 1'b1;
      key_sync2 <= 1'b1;
    end else begin
      key_sync1 <= KEY;
      key_sync2 <= key_sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Debounce. key_level follows key_sync2 only after they have disagreed for
  // DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle restarts the
  // count. A press event is a single-cycle pulse registered together with a
  // 1->0 change of key_level. Holding the key never produces a second one,
  // and a release produces none.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      key_level  <= 1'b1;
      stable_cnt <= '0;
      press_evt  <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (key_sync2 == key_level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        key_level  <= key_sync2;
        stable_cnt <= '0;
        press_evt  <= ~key_sync2;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Request FSM. Press events that arrive outside WAIT_PRESS are dropped.
  // A key that is already held when the request starts therefore has to be
  // released and pressed again. In WAIT_PRESS, halt and a dropped
  // input_flag take priority over a press in the same cycle.
  // -------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (input_flag && !halt) state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (halt || !input_flag) begin
          state_next = IDLE;
        end else if (press_evt) begin
          state_next = DONE;
          capture    = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // SW is sampled in the press-event cycle. The register becomes visible in
  // the DONE cycle, the same cycle input_done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else if (capture) begin
      data_out <= {14'b0, SW};
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. stall is combinational, so a new IN request freezes the
  // pipeline in the same cycle input_flag rises. Any halt releases it at
  // once.
  // -------------------------------------------------------------------------
  assign waiting    = (state == WAIT_PRESS);
  assign input_done = (state == DONE);
  assign stall      = !halt && (waiting || ((state == IDLE) && input_flag));

endmodule

// File: doc/switch_input.md
SWITCH_INPUT -- requirements
Module: switch_input

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, number of consecutive stable cycles required before the debounced key level changes (board build overrides it, e.g. 500000).
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: halt  input  1  processor halted; aborts any pending input request.
REQ-005 Port: input_flag  input  1  processor executing an IN instruction; held high until stall drops.
REQ-006 Port: SW  input  18  board switches; value to be read.
REQ-007 Port: KEY  input  1  board push button, active-low, asynchronous to clk.
REQ-008 Port: data_out  output  32  last captured switch value, zero-extended ({14'b0, SW}).
REQ-009 Port: stall  output  1  freezes processor PC/pipeline while high.
REQ-010 Port: input_done  output  1  one-cycle pulse: data_out was updated this cycle.
REQ-011 Port: waiting  output  1  high while a key press is awaited (drives a prompt LED).

Function
REQ-012 KEY SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce: the debounced level SHALL change only after the synchronized KEY differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter to 0.
REQ-014 Press event SHALL be a one-cycle pulse on a debounced 1->0 transition; holding the key produces exactly one event; release produces none.
REQ-015 FSM states: IDLE, WAIT_PRESS, DONE.
REQ-016 IDLE: input_flag=1 and halt=0 -> WAIT_PRESS; otherwise stay.
REQ-017 WAIT_PRESS: press event -> DONE, and data_out SHALL load {14'b0, SW} sampled in the press-event cycle.
REQ-018 WAIT_PRESS: input_flag=0 or halt=1 -> IDLE, data_out unchanged, no input_done; halt has priority over a same-cycle press event.
REQ-019 DONE: input_done=1 for exactly this cycle; unconditionally -> IDLE next cycle; input_flag ignored in DONE.
REQ-020 stall SHALL be combinational: 1 when state=WAIT_PRESS, or state=IDLE with input_flag=1 and halt=0; 0 in DONE and whenever halt=1.
REQ-021 waiting SHALL equal (state==WAIT_PRESS).
REQ-022 Press events in IDLE or DONE SHALL be discarded; a key already held when input_flag rises does not satisfy the request, and a new press (after release) is required.
REQ-023 data_out SHALL hold its value except on the capture of REQ-017; SW changes otherwise have no effect.
REQ-024 Latency: input_done asserts the cycle after the press event, which follows the last KEY edge by DEBOUNCE_CYCLES+2 cycles (synchronizer + debounce); stall falls in the same cycle input_done rises.
REQ-025 Back-to-back IN: input_flag re-asserted the cycle after DONE SHALL start a new WAIT_PRESS normally.

Reset
REQ-026 On reset=1 at a rising edge: state=IDLE, data_out=0, input_done=0, synchronizer flops and debounced level=1 (released), debounce counter=0, pending press event cleared.
REQ-027 Outputs after reset: stall=0 (unless input_flag=1), waiting=0; reset in WAIT_PRESS SHALL abort the request without capture.
REQ-028 Reset SHALL override halt, input_flag and KEY in the same cycle.

Verification
REQ-029 Basic read: SW=18'h2A5F3, input_flag=1, KEY low 40 cycles then high (DEBOUNCE_CYCLES=16) -> stall high until press event+1, single input_done pulse, data_out=32'h0002A5F3.
REQ-030 Bounce: KEY toggles every 5 cycles for 60 cycles, then stays low -> exactly one press event, 18 cycles after the final falling edge; no captures during the bouncing.
REQ-031 Held key: KEY held low before input_flag rises -> waiting=1, no capture; release, then press -> capture occurs, data_out=current SW.
REQ-032 Abort: in WAIT_PRESS assert halt=1 in the same cycle as the press event -> IDLE, stall=0, data_out unchanged, input_done=0.
REQ-033 Reset mid-wait: reset during WAIT_PRESS with data_out=32'h15 -> data_out=0, state IDLE, waiting=0; a subsequent press with input_flag=0 -> no capture.
REQ-034 Back-to-back: two IN requests with SW=5 then SW=9 and two separate presses -> two input_done pulses, data_out=5 then 9.
